// File: rtl/issue_hazard_scoreboard.sv
`default_nettype none
// ============================================================================
//  Module   : issue_hazard_scoreboard
//  Purpose  : N-lane issue stage. Decodes each lane's opcode into effective
//             src1/src2/dest (unused fields forced to x0), tracks in-flight
//             destinations in a busy table, detects RAW/WAW hazards against
//             in-flight writers and older lanes of the same bundle, and
//             issues the longest hazard-free in-order prefix into a single
//             registered output stage with a valid/ready handshake.
//  Ports    : clk, rst_n (async, active-low), flush (sync kill)
//             in_valid/in_opcode/in_src1/in_src2/in_dest : incoming bundle
//             in_accept_cnt : lanes consumed this cycle (combinational)
//             out_valid/out_src1/out_src2/out_dest       : registered bundle
//             out_ready     : downstream takes the whole output bundle
//             wb_valid/wb_rd: writeback ports clearing busy bits
//             busy          : busy table (debug)
//  Revision : 1.0  initial release
// ============================================================================
module issue_hazard_scoreboard #(
  parameter int LANES   = 2,
  parameter int NREGS   = 32,
  parameter int REGW    = 5,
  parameter int WBPORTS = 2
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic                           flush,
  input  logic [LANES-1:0]               in_valid,
  input  logic [LANES*7-1:0]             in_opcode,
  input  logic [LANES*REGW-1:0]          in_src1,
  input  logic [LANES*REGW-1:0]          in_src2,
  input  logic [LANES*REGW-1:0]          in_dest,
  output logic [$clog2(LANES+1)-1:0]     in_accept_cnt,
  output logic [LANES-1:0]               out_valid,
  output logic [LANES*REGW-1:0]          out_src1,
  output logic [LANES*REGW-1:0]          out_src2,
  output logic [LANES*REGW-1:0]          out_dest,
  input  logic                           out_ready,
  input  logic [WBPORTS-1:0]             wb_valid,
  input  logic [WBPORTS*REGW-1:0]        wb_rd,
  output logic [NREGS-1:0]               busy
);

  localparam int c_CNTW = $clog2(LANES + 1);

  logic [REGW-1:0]      w_src1 [LANES];
  logic [REGW-1:0]      w_src2 [LANES];
  logic [REGW-1:0]      w_dest [LANES];
  logic [LANES-1:0]     w_blocked;
  logic [NREGS-1:0]     w_wb_hit;
  logic [NREGS-1:0]     w_eff_busy;
  logic [NREGS-1:0]     w_busy_nxt;
  logic [c_CNTW-1:0]    w_cand_cnt;
  logic [c_CNTW-1:0]    w_accept_cnt;
  logic                 w_stall;

  logic [NREGS-1:0]     r_busy;
  logic [LANES-1:0]     r_out_valid;
  logic [LANES*REGW-1:0] r_out_src1;
  logic [LANES*REGW-1:0] r_out_src2;
  logic [LANES*REGW-1:0] r_out_dest;

  // Per-lane opcode decode: which raw fields the instruction really uses.
  generate
    for (genvar g = 0; g < LANES; g++) begin : g_decode
      logic w_use1, w_use2, w_used;
      always_comb begin
        w_use1 = 1'b1;
        w_use2 = 1'b1;
        w_used = 1'b1;
        case (in_opcode[g*7 +: 7])
          7'b0010011, 7'b0000011, 7'b1100111: begin
            w_use2 = 1'b0;
          end
          7'b0100011, 7'b1100011: begin
            w_used = 1'b0;
          end
          7'b1101111, 7'b0010111, 7'b0110111: begin
            w_use1 = 1'b0;
            w_use2 = 1'b0;
          end
          default: ;
        endcase
      end
      assign w_src1[g] = w_use1 ? in_src1[g*REGW +: REGW] : '0;
      assign w_src2[g] = w_use2 ? in_src2[g*REGW +: REGW] : '0;
      assign w_dest[g] = w_used ? in_dest[g*REGW +: REGW] : '0;
    end
  endgenerate

  // Same-cycle writebacks are bypassed: a register being written back now
  // no longer counts as busy for hazard purposes.
  always_comb begin
    w_wb_hit = '0;
    for (int r = 0; r < NREGS; r++) begin
      for (int k = 0; k < WBPORTS; k++) begin
        if (wb_valid[k] && (wb_rd[k*REGW +: REGW] == REGW'(r))) begin
          w_wb_hit[r] = 1'b1;
        end
      end
    end
  end

  assign w_eff_busy = r_busy & ~w_wb_hit;

  // Hazard detection. x0 never participates.
  always_comb begin
    w_blocked = '0;
    for (int i = 0; i < LANES; i++) begin
      if ((w_src1[i] != '0) && w_eff_busy[w_src1[i]]) w_blocked[i] = 1'b1;
      if ((w_src2[i] != '0) && w_eff_busy[w_src2[i]]) w_blocked[i] = 1'b1;
      if ((w_dest[i] != '0) && w_eff_busy[w_dest[i]]) w_blocked[i] = 1'b1;
      for (int j = 0; j < i; j++) begin
        if ((w_dest[j] != '0) &&
            ((w_dest[j] == w_src1[i]) || (w_dest[j] == w_src2[i]) ||
             (w_dest[j] == w_dest[i]))) begin
          w_blocked[i] = 1'b1;
        end
      end
    end
  end

  // Length of the leading run of valid, unblocked lanes.
  always_comb begin
    logic v_run;
    w_cand_cnt = '0;
    v_run      = 1'b1;
    for (int i = 0; i < LANES; i++) begin
      if (v_run && in_valid[i] && !w_blocked[i]) begin
        w_cand_cnt = w_cand_cnt + c_CNTW'(1);
      end else begin
        v_run = 1'b0;
      end
    end
  end

  assign w_stall      = (r_out_valid != '0) && !out_ready;
  assign w_accept_cnt = (w_stall || flush) ? '0 : w_cand_cnt;

  // Busy update: clear on writeback, then set for accepted writers, so a
  // set wins over a same-cycle clear of the same register.
  always_comb begin
    w_busy_nxt = r_busy & ~w_wb_hit;
    for (int i = 0; i < LANES; i++) begin
      if ((i < int'(w_accept_cnt)) && (w_dest[i] != '0)) begin
        w_busy_nxt[w_dest[i]] = 1'b1;
      end
    end
    w_busy_nxt[0] = 1'b0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_busy <= '0;
    end else if (flush) begin
      r_busy <= '0;
    end else begin
      r_busy <= w_busy_nxt;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_out_valid <= '0;
      r_out_src1  <= '0;
      r_out_src2  <= '0;
      r_out_dest  <= '0;
    end else if (flush) begin
      r_out_valid <= '0;
    end else if (!w_stall) begin
      for (int i = 0; i < LANES; i++) begin
        if (i < int'(w_accept_cnt)) begin
          r_out_valid[i]               <= 1'b1;
          r_out_src1[i*REGW +: REGW]   <= w_src1[i];
          r_out_src2[i*REGW +: REGW]   <= w_src2[i];
          r_out_dest[i*REGW +: REGW]   <= w_dest[i];
        end else begin
          r_out_valid[i]               <= 1'b0;
          r_out_src1[i*REGW +: REGW]   <= '0;
          r_out_src2[i*REGW +: REGW]   <= '0;
          r_out_dest[i*REGW +: REGW]   <= '0;
        end
      end
    end
  end

  assign in_accept_cnt = w_accept_cnt;
  assign out_valid     = r_out_valid;
  assign out_src1      = r_out_src1;
  assign out_src2      = r_out_src2;
  assign out_dest      = r_out_dest;
  assign busy          = r_busy;

endmodule
`default_nettype wire

// File: tb/tb_issue_hazard_scoreboard.sv
`default_nettype none
// ============================================================================
//  Module   : tb_issue_hazard_scoreboard
//  Purpose  : Directed self-checking bench for issue_hazard_scoreboard with
//             LANES=2, NREGS=32, REGW=5, WBPORTS=2.
//  Revision : 1.0  initial release
// ============================================================================
module tb_issue_hazard_scoreboard;

  localparam int LANES   = 2;
  localparam int NREGS   = 32;
  localparam int REGW    = 5;
  localparam int WBPORTS = 2;

  localparam logic [6:0] c_ADDI = 7'b0010011;
  localparam logic [6:0] c_ADD  = 7'b0110011;
  localparam logic [6:0] c_SW   = 7'b0100011;
  localparam logic [6:0] c_LUI  = 7'b0110111;

  logic                         clk;
  logic                         rst_n;
  logic                         flush;
  logic [LANES-1:0]             in_valid;
  logic [LANES*7-1:0]           in_opcode;
  logic [LANES*REGW-1:0]        in_src1, in_src2, in_dest;
  logic [$clog2(LANES+1)-1:0]   in_accept_cnt;
  logic [LANES-1:0]             out_valid;
  logic [LANES*REGW-1:0]        out_src1, out_src2, out_dest;
  logic                         out_ready;
  logic [WBPORTS-1:0]           wb_valid;
  logic [WBPORTS*REGW-1:0]      wb_rd;
  logic [NREGS-1:0]             busy;

  int n_pass  = 0;
  int n_total = 0;

  issue_hazard_scoreboard #(
    .LANES(LANES), .NREGS(NREGS), .REGW(REGW), .WBPORTS(WBPORTS)
  ) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .in_valid(in_valid), .in_opcode(in_opcode),
    .in_src1(in_src1), .in_src2(in_src2), .in_dest(in_dest),
    .in_accept_cnt(in_accept_cnt),
    .out_valid(out_valid), .out_src1(out_src1), .out_src2(out_src2),
    .out_dest(out_dest), .out_ready(out_ready),
    .wb_valid(wb_valid), .wb_rd(wb_rd), .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
  endtask

  task automatic set_lane(input int l, input logic [6:0] op, input logic [4:0] s1,
                          input logic [4:0] s2, input logic [4:0] d);
    in_opcode[l*7 +: 7]     = op;
    in_src1[l*REGW +: REGW] = s1;
    in_src2[l*REGW +: REGW] = s2;
    in_dest[l*REGW +: REGW] = d;
  endtask

  // Advance one clock and sample just after the edge.
  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n = 1'b0; flush = 1'b0; in_valid = '0; in_opcode = '0;
    in_src1 = '0; in_src2 = '0; in_dest = '0; out_ready = 1'b1;
    wb_valid = '0; wb_rd = '0;
    repeat (2) @(posedge clk);
    #2;
    chk("reset_out_valid", 32'(out_valid), 32'd0);
    chk("reset_busy", busy, 32'd0);
    chk("reset_out_dest", 32'(out_dest), 32'd0);
    chk("reset_accept", 32'(in_accept_cnt), 32'd0);
    rst_n = 1'b1;
    tick();

    // Two independent writers.
    set_lane(0, c_ADDI, 5'd1, 5'd9, 5'd5);
    set_lane(1, c_ADD,  5'd2, 5'd3, 5'd6);
    in_valid = 2'b11;
    #1 chk("s1_accept", 32'(in_accept_cnt), 32'd2);
    tick();
    chk("s1_out_valid", 32'(out_valid), 32'h3);
    chk("s1_out_dest", 32'(out_dest), 32'({5'd6, 5'd5}));
    chk("s1_out_src2", 32'(out_src2), 32'({5'd3, 5'd0}));
    chk("s1_busy", busy, 32'h0000_0060);

    // Intra-bundle RAW on x7.
    set_lane(0, c_ADDI, 5'd1, 5'd0, 5'd7);
    set_lane(1, c_ADD,  5'd7, 5'd1, 5'd8);
    #1 chk("s2_accept", 32'(in_accept_cnt), 32'd1);
    tick();
    chk("s2_out_valid", 32'(out_valid), 32'h1);
    chk("s2_out_dest", 32'(out_dest), 32'({5'd0, 5'd7}));
    chk("s2_busy", busy, 32'h0000_00E0);

    // Re-present the blocked reader alone; waits for x7 writeback.
    set_lane(0, c_ADD, 5'd7, 5'd1, 5'd8);
    set_lane(1, 7'd0, 5'd0, 5'd0, 5'd0);
    in_valid = 2'b01;
    #1 chk("s3_accept_blocked", 32'(in_accept_cnt), 32'd0);
    tick();
    chk("s3_out_valid_empty", 32'(out_valid), 32'h0);
    chk("s3_accept_still_blocked", 32'(in_accept_cnt), 32'd0);
    wb_valid = 2'b01; wb_rd = {5'd0, 5'd7};
    #1 chk("s3_accept_bypass", 32'(in_accept_cnt), 32'd1);
    tick();
    wb_valid = '0; wb_rd = '0;
    chk("s3_busy", busy, 32'h0000_0160);
    chk("s3_out_dest", 32'(out_dest), 32'({5'd0, 5'd8}));

    // Store has no dest, lui has no sources (x8 busy is ignored).
    set_lane(0, c_SW,  5'd1, 5'd2, 5'd9);
    set_lane(1, c_LUI, 5'd8, 5'd8, 5'd10);
    in_valid = 2'b11;
    #1 chk("s4_accept", 32'(in_accept_cnt), 32'd2);
    tick();
    chk("s4_out_dest", 32'(out_dest), 32'({5'd10, 5'd0}));
    chk("s4_out_src1", 32'(out_src1), 32'({5'd0, 5'd1}));
    chk("s4_out_src2", 32'(out_src2), 32'({5'd0, 5'd2}));
    chk("s4_busy", busy, 32'h0000_0560);

    // Downstream stall for three cycles.
    set_lane(0, c_ADDI, 5'd1, 5'd0, 5'd11);
    set_lane(1, c_ADDI, 5'd2, 5'd0, 5'd12);
    out_ready = 1'b0;
    for (int c = 0; c < 3; c++) begin
      #1 chk("s5_stall_accept", 32'(in_accept_cnt), 32'd0);
      tick();
      chk("s5_stall_valid", 32'(out_valid), 32'h3);
      chk("s5_stall_dest", 32'(out_dest), 32'({5'd10, 5'd0}));
      chk("s5_stall_busy", busy, 32'h0000_0560);
    end
    out_ready = 1'b1;
    #1 chk("s5_release_accept", 32'(in_accept_cnt), 32'd2);
    tick();
    chk("s5_release_dest", 32'(out_dest), 32'({5'd12, 5'd11}));
    chk("s5_busy", busy, 32'h0000_1D60);

    // Same-cycle writeback of x5 plus a new x5 writer; x6 written back too.
    set_lane(0, c_ADDI, 5'd3, 5'd0, 5'd5);
    set_lane(1, 7'd0, 5'd0, 5'd0, 5'd0);
    in_valid = 2'b01;
    wb_valid = 2'b11; wb_rd = {5'd5, 5'd6};
    #1 chk("s6_accept", 32'(in_accept_cnt), 32'd1);
    tick();
    wb_valid = '0; wb_rd = '0;
    chk("s6_busy", busy, 32'h0000_1D20);

    // Fill the output stage, then flush.
    set_lane(0, c_ADDI, 5'd1, 5'd0, 5'd13);
    set_lane(1, c_ADDI, 5'd2, 5'd0, 5'd14);
    in_valid = 2'b11;
    tick();
    chk("s7_out_valid", 32'(out_valid), 32'h3);
    chk("s7_busy", busy, 32'h0000_7D20);
    flush = 1'b1;
    set_lane(0, c_ADDI, 5'd1, 5'd0, 5'd15);
    set_lane(1, c_ADDI, 5'd2, 5'd0, 5'd16);
    #1 chk("s7_flush_accept", 32'(in_accept_cnt), 32'd0);
    tick();
    flush = 1'b0;
    in_valid = '0;
    chk("s7_flush_busy", busy, 32'd0);
    chk("s7_flush_valid", 32'(out_valid), 32'h0);
    wb_valid = 2'b01; wb_rd = {5'd0, 5'd5};
    #1 chk("s7_idle_accept", 32'(in_accept_cnt), 32'd0);
    tick();
    wb_valid = '0; wb_rd = '0;
    chk("s7_wb_nonbusy", busy, 32'd0);

    // Intra-bundle WAW on x20.
    set_lane(0, c_ADDI, 5'd1, 5'd0, 5'd20);
    set_lane(1, c_LUI,  5'd0, 5'd0, 5'd20);
    in_valid = 2'b11;
    #1 chk("s8_waw_accept", 32'(in_accept_cnt), 32'd1);
    tick();
    in_valid = '0;
    chk("s8_busy", busy, 32'h0010_0000);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
`default_nettype wire
